// File: rtl/disk_uart_pkg.sv
// Shared definitions for the disk-side UART: FSM state encodings and timing constants.
package disk_uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud
    localparam int TX_GAP_CYCLES        = 2;    // idle cycles after each transmitted frame

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: synchronises rxd, finds mid-bit sample points from the start edge and
// emits a one-cycle valid (good stop bit) or frame_err (stop bit low) per frame.
module uart_rx_core
    import disk_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       valid,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    logic [1:0]        sync;
    logic              rx_s;
    rx_state_t         state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shreg, shreg_n;
    logic              valid_n, ferr_n;

    assign rx_s = sync[1];
    assign data = shreg;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rxd};
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_IDLE;
            baud      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bit_cnt   <= bit_n;
            shreg     <= shreg_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // RX next state: half-bit start qualification, then one sample per bit period.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_n = RX_START;
                    baud_n  = '0;
                end
            end
            RX_START: begin
                if (baud == BAUD_HALF) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    // Line back high at mid-start means a glitch, not a frame.
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            RX_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    if (bit_cnt == 3'd7) state_n = RX_STOP;
                    else                 bit_n   = bit_cnt + 3'd1;
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            RX_STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = RX_IDLE;
                    if (rx_s) valid_n = 1'b1;
                    else      ferr_n  = 1'b1;
                end else begin
                    baud_n = baud + BAUD_ONE;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/disk_uart_port.sv
// Byte-request UART port for the disk controller: TX framing, one-entry RX pending buffer,
// delivery handshake and sticky error flags.
module disk_uart_port
    import disk_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       write_done,
    output logic       read_done,
    input  logic       rxd,
    output logic       txd,
    input  logic       err_clr,
    output logic       framing_err,
    output logic       overrun
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [1:0]        GAP_LAST  = 2'(TX_GAP_CYCLES - 1);

    tx_state_t         tx_state, tx_state_n;
    logic [BAUD_W-1:0] tx_baud, tx_baud_n;
    logic [2:0]        tx_bit, tx_bit_n;
    logic [7:0]        tx_shreg, tx_shreg_n;
    logic [1:0]        tx_gap, tx_gap_n;
    logic              txd_n, write_done_n;

    logic              rx_valid, rx_ferr;
    logic [7:0]        rx_byte;
    logic              pending, deliver;
    logic [7:0]        pend_byte;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .valid     (rx_valid),
        .data      (rx_byte),
        .frame_err (rx_ferr)
    );

    assign deliver = pending & enable & ~we;

    // TX state register; txd and write_done are registered so they are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_baud    <= '0;
            tx_bit     <= '0;
            tx_shreg   <= '0;
            tx_gap     <= '0;
            txd        <= 1'b1;
            write_done <= 1'b0;
        end else begin
            tx_state   <= tx_state_n;
            tx_baud    <= tx_baud_n;
            tx_bit     <= tx_bit_n;
            tx_shreg   <= tx_shreg_n;
            tx_gap     <= tx_gap_n;
            txd        <= txd_n;
            write_done <= write_done_n;
        end
    end

    // TX next state: txd is loaded with the upcoming bit on each bit boundary.
    always_comb begin
        tx_state_n   = tx_state;
        tx_baud_n    = tx_baud;
        tx_bit_n     = tx_bit;
        tx_shreg_n   = tx_shreg;
        tx_gap_n     = tx_gap;
        txd_n        = txd;
        write_done_n = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                txd_n = 1'b1;
                if (enable && we) begin
                    tx_shreg_n = data_in;
                    txd_n      = 1'b0;
                    tx_baud_n  = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_baud == BAUD_LAST) begin
                    tx_baud_n  = '0;
                    tx_bit_n   = '0;
                    txd_n      = tx_shreg[0];
                    tx_state_n = TX_DATA;
                end else begin
                    tx_baud_n = tx_baud + BAUD_ONE;
                end
            end
            TX_DATA: begin
                if (tx_baud == BAUD_LAST) begin
                    tx_baud_n = '0;
                    if (tx_bit == 3'd7) begin
                        txd_n      = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_shreg_n = tx_shreg >> 1;
                        txd_n      = tx_shreg[1];
                        tx_bit_n   = tx_bit + 3'd1;
                    end
                end else begin
                    tx_baud_n = tx_baud + BAUD_ONE;
                end
            end
            TX_STOP: begin
                if (tx_baud == BAUD_LAST) begin
                    tx_baud_n    = '0;
                    tx_gap_n     = '0;
                    write_done_n = 1'b1;
                    tx_state_n   = TX_GAP;
                end else begin
                    tx_baud_n = tx_baud + BAUD_ONE;
                end
            end
            TX_GAP: begin
                // Lets the controller present its next byte before we look at enable again.
                if (tx_gap == GAP_LAST) tx_state_n = TX_IDLE;
                else                    tx_gap_n   = tx_gap + 2'd1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Pending buffer, delivery and sticky flags; a new error beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            pend_byte   <= '0;
            data_out    <= '0;
            read_done   <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            read_done <= deliver;
            if (deliver) data_out <= pend_byte;
            if (rx_valid) begin
                pend_byte <= rx_byte;
                pending   <= 1'b1;
            end else if (deliver) begin
                pending <= 1'b0;
            end
            if (rx_valid && pending && !deliver) overrun <= 1'b1;
            else if (err_clr)                    overrun <= 1'b0;
            if (rx_ferr)      framing_err <= 1'b1;
            else if (err_clr) framing_err <= 1'b0;
        end
    end

endmodule
